mux_scan_sequencer: RTL



---
 rtl/mux_scan_pkg.sv | 17 +
 rtl/mux_scan_settle_cnt.sv | 29 ++
 rtl/mux_scan_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state type, default select width and word-width helper
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    VALID = 2'd2
  } scan_state_e;

  localparam int DEF_SEL_W = 4;

  // Captured word holds one bit per mux input.
  function automatic int word_w(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// rtl/mux_scan_settle_cnt.sv - loadable down-counter timing the select settle window
// Ports: clk, rst_n (sync active-low), load/load_val (load wins over en),
//        en (decrement, saturates at 0), zero (count is 0).
module mux_scan_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a mux select over an index range and captures a word
// Ports: clk, rst_n (sync active-low); start, first_sel, last_sel (scan request);
//        sel -> mux select, mux_out <- mux bit; busy; word/word_valid/word_ready
//        (captured word handshake); parity (only with MUX_SCAN_PARITY_EN defined).
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SEL_W  = DEF_SEL_W,
  parameter int SETTLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SEL_W-1:0]          first_sel,
  input  logic [SEL_W-1:0]          last_sel,
  output logic [SEL_W-1:0]          sel,
  input  logic                      mux_out,
  output logic                      busy,
  output logic [word_w(SEL_W)-1:0]  word,
  output logic                      word_valid,
  input  logic                      word_ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                      parity
`endif
);

  localparam int WORD_W = word_w(SEL_W);
  localparam int CNT_W  = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  scan_state_e       state, state_nxt;
  logic [SEL_W-1:0]  last_q;
  logic              cnt_load, cnt_en, cnt_zero;
  logic              start_acc, sample, finish, advance, release_word;
  logic [WORD_W-1:0] word_cap;

  mux_scan_settle_cnt #(
    .W (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(SETTLE)),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    start_acc    = 1'b0;
    sample       = 1'b0;
    finish       = 1'b0;
    advance      = 1'b0;
    release_word = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else begin
          sample = 1'b1;
          if (sel == last_q) begin
            finish    = 1'b1;
            state_nxt = VALID;
          end else begin
            advance  = 1'b1;
            cnt_load = 1'b1;
          end
        end
      end
      VALID: begin
        // start is deliberately not looked at here, even on the leaving edge.
        if (word_ready) begin
          release_word = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word with the current mux bit merged in at the current index.
  always_comb begin
    word_cap      = word;
    word_cap[sel] = mux_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel        <= '0;
      last_q     <= '0;
      busy       <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      if (start_acc) begin
        sel    <= first_sel;
        last_q <= last_sel;
        word   <= '0;
        busy   <= 1'b1;
      end
      if (sample) begin
        word <= word_cap;
      end
      if (advance) begin
        sel <= sel + SEL_W'(1);
      end
      if (finish) begin
        busy       <= 1'b0;
        word_valid <= 1'b1;
      end
      if (release_word) begin
        word_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (finish) begin
      parity <= ^word_cap;
    end
  end
`endif

endmodule
